// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - load/fetch/decode/execute stage sequencer with halt park and retired counter
// Optional single-step support: define SINGLE_STEP_EN.
module stage_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 12,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic [ADDR_W-1:0]  pmem_addr,
    output logic [INSTR_W-1:0] pmem_wdata,
    output logic               pmem_wr,
    output logic [1:0]         stage,
    input  logic               halt_req,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
`ifdef SINGLE_STEP_EN
    ,
    input  logic               step_mode,
    input  logic               step
`endif
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_PARK
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [CNT_W-1:0]   count_next;
    logic [1:0]         stage_next;
    logic               accept;
    logic               park_enter;
    logic               park_hold;

    // load_ready is only ever high in LOAD, so it alone qualifies the write
    assign accept     = load_valid & load_ready;
    assign pmem_wr    = accept;
    assign pmem_wdata = load_data;

`ifdef SINGLE_STEP_EN
    assign park_enter = halt_req | step_mode;
    assign park_hold  = halt_req | (step_mode & ~step);
`else
    assign park_enter = halt_req;
    assign park_hold  = halt_req;
`endif

    always_comb begin
        state_next = state;
        addr_next  = pmem_addr;
        count_next = instr_count;
        case (state)
            S_LOAD: begin
                if (accept) begin
                    // the last address slot ends the image even without load_last
                    if (load_last || (pmem_addr == {ADDR_W{1'b1}})) begin
                        state_next = S_FETCH;
                        addr_next  = '0;
                    end else begin
                        addr_next = pmem_addr + ADDR_W'(1);
                    end
                end
            end
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXECUTE;
            S_EXECUTE: begin
                if (instr_count != {CNT_W{1'b1}}) begin
                    count_next = instr_count + CNT_W'(1);
                end
                state_next = park_enter ? S_PARK : S_FETCH;
            end
            S_PARK:   state_next = park_hold ? S_PARK : S_FETCH;
            default:  state_next = S_LOAD;
        endcase
    end

    // PARK presents DECODE to the control unit since that stage has no side effects
    always_comb begin
        stage_next = 2'b00;
        case (state_next)
            S_LOAD:    stage_next = 2'b00;
            S_FETCH:   stage_next = 2'b01;
            S_DECODE:  stage_next = 2'b10;
            S_EXECUTE: stage_next = 2'b11;
            S_PARK:    stage_next = 2'b10;
            default:   stage_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD;
            pmem_addr   <= '0;
            load_ready  <= 1'b0;
            stage       <= 2'b00;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_next;
            pmem_addr   <= addr_next;
            load_ready  <= (state_next == S_LOAD);
            stage       <= stage_next;
            halted      <= (state_next == S_PARK);
            instr_count <= count_next;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed self-checking bench for stage_sequencer
module tb_stage_sequencer;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [11:0] load_data;
    logic        load_last;
    logic        halt_req;

    logic        load_ready, pmem_wr, halted;
    logic [7:0]  pmem_addr;
    logic [11:0] pmem_wdata;
    logic [1:0]  stage;
    logic [15:0] instr_count;

    logic        load_ready2, pmem_wr2, halted2;
    logic [1:0]  pmem_addr2;
    logic [11:0] pmem_wdata2;
    logic [1:0]  stage2;
    logic [15:0] instr_count2;

    logic        load_ready3, pmem_wr3, halted3;
    logic [7:0]  pmem_addr3;
    logic [11:0] pmem_wdata3;
    logic [1:0]  stage3;
    logic [1:0]  instr_count3;

`ifdef SINGLE_STEP_EN
    logic step_mode;
    logic step;
`endif

    int checks;
    int failures;

    stage_sequencer #(.ADDR_W(8), .INSTR_W(12), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_wr(pmem_wr), .stage(stage),
        .halt_req(halt_req), .halted(halted), .instr_count(instr_count)
`ifdef SINGLE_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    stage_sequencer #(.ADDR_W(2), .INSTR_W(12), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready2), .pmem_addr(pmem_addr2),
        .pmem_wdata(pmem_wdata2), .pmem_wr(pmem_wr2), .stage(stage2),
        .halt_req(halt_req), .halted(halted2), .instr_count(instr_count2)
`ifdef SINGLE_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    stage_sequencer #(.ADDR_W(8), .INSTR_W(12), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready3), .pmem_addr(pmem_addr3),
        .pmem_wdata(pmem_wdata3), .pmem_wr(pmem_wr3), .stage(stage3),
        .halt_req(halt_req), .halted(halted3), .instr_count(instr_count3)
`ifdef SINGLE_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        halt_req   = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic load_one();
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 12'h5a5;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        halt_req   = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({stage, pmem_addr, load_ready, halted, instr_count} !== 28'h0) begin
            failures++;
            $display("FAIL reset_state got stage=%0d addr=%0d rdy=%0b halted=%0b cnt=%0d exp all zero",
                     stage, pmem_addr, load_ready, halted, instr_count);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b exp=1", load_ready);
        end
    endtask

    task automatic test_basic_load();
        logic [1:0] exp_stage [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_last  = (i == 3);
            load_data  = 12'h100 + 12'(i);
            #1;
            checks++;
            if ({pmem_wr, pmem_addr, pmem_wdata} !== {1'b1, 8'(i), 12'h100 + 12'(i)}) begin
                failures++;
                $display("FAIL basic_write%0d got wr=%0b addr=%0d data=%0h exp wr=1 addr=%0d data=%0h",
                         i, pmem_wr, pmem_addr, pmem_wdata, i, 12'h100 + 12'(i));
            end
            cyc();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++;
        if ({load_ready, pmem_addr} !== 9'h0) begin
            failures++;
            $display("FAIL basic_end got rdy=%0b addr=%0d exp rdy=0 addr=0", load_ready, pmem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (stage !== exp_stage[i]) begin
                failures++;
                $display("FAIL basic_stage%0d got=%0d exp=%0d", i, stage, exp_stage[i]);
            end
            if (i < 3) cyc();
        end
        checks++;
        if (instr_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=1", instr_count);
        end
    endtask

    task automatic test_valid_toggle();
        logic       vld  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] addr [5] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load_valid = vld[i];
            load_last  = (i == 4);
            load_data  = 12'h0a0 + 12'(i);
            #1;
            checks++;
            if ({pmem_wr, pmem_addr} !== {vld[i], addr[i]}) begin
                failures++;
                $display("FAIL toggle%0d got wr=%0b addr=%0d exp wr=%0b addr=%0d",
                         i, pmem_wr, pmem_addr, vld[i], addr[i]);
            end
            cyc();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++;
        if (stage !== 2'b01) begin
            failures++;
            $display("FAIL toggle_end got stage=%0d exp=1", stage);
        end
    endtask

    task automatic test_last_slot();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_last  = 1'b0;
            load_data  = 12'h200 + 12'(i);
            #1;
            checks++;
            if ({pmem_wr2, pmem_addr2} !== {1'b1, 2'(i)}) begin
                failures++;
                $display("FAIL slot_write%0d got wr=%0b addr=%0d exp wr=1 addr=%0d",
                         i, pmem_wr2, pmem_addr2, i);
            end
            cyc();
        end
        load_data = 12'h204;
        #1;
        checks++;
        if ({load_ready2, pmem_wr2, stage2, pmem_addr2} !== 6'b00_01_00) begin
            failures++;
            $display("FAIL slot_fifth got rdy=%0b wr=%0b stage=%0d addr=%0d exp rdy=0 wr=0 stage=1 addr=0",
                     load_ready2, pmem_wr2, stage2, pmem_addr2);
        end
        load_valid = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        load_one();
        halt_req = 1'b1;
        cyc();
        cyc();
        cyc();
        checks++;
        if ({stage, halted, instr_count} !== {2'b10, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL halt_park got stage=%0d halted=%0b cnt=%0d exp stage=2 halted=1 cnt=1",
                     stage, halted, instr_count);
        end
        cyc();
        checks++;
        if ({stage, halted, instr_count} !== {2'b10, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL halt_hold got stage=%0d halted=%0b cnt=%0d exp stage=2 halted=1 cnt=1",
                     stage, halted, instr_count);
        end
        halt_req = 1'b0;
        cyc();
        checks++;
        if ({stage, halted} !== {2'b01, 1'b0}) begin
            failures++;
            $display("FAIL halt_release got stage=%0d halted=%0b exp stage=1 halted=0", stage, halted);
        end
        cyc();
        cyc();
        cyc();
        checks++;
        if ({stage, instr_count} !== {2'b01, 16'd2}) begin
            failures++;
            $display("FAIL halt_resume got stage=%0d cnt=%0d exp stage=1 cnt=2", stage, instr_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_valid = 1'b1;
        load_data  = 12'h301;
        cyc();
        load_data = 12'h302;
        rst = 1'b1;
        cyc();
        checks++;
        if ({stage, pmem_addr, load_ready} !== 11'h0) begin
            failures++;
            $display("FAIL rst_load got stage=%0d addr=%0d rdy=%0b exp 0 0 0", stage, pmem_addr, load_ready);
        end
        rst = 1'b0;
        load_valid = 1'b0;
        cyc();
        load_one();
        for (int i = 0; i < 5; i++) cyc();
        checks++;
        if ({stage, instr_count} !== {2'b11, 16'd1}) begin
            failures++;
            $display("FAIL rst_pre got stage=%0d cnt=%0d exp stage=3 cnt=1", stage, instr_count);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if ({stage, pmem_addr, instr_count} !== 26'h0) begin
            failures++;
            $display("FAIL rst_exec got stage=%0d addr=%0d cnt=%0d exp 0 0 0", stage, pmem_addr, instr_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        load_one();
        for (int i = 0; i < 15; i++) cyc();
        checks++;
        if ({stage3, instr_count3} !== {2'b01, 2'd3}) begin
            failures++;
            $display("FAIL saturate got stage=%0d cnt=%0d exp stage=1 cnt=3", stage3, instr_count3);
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        step_mode = 1'b1;
        do_reset();
        load_one();
        cyc();
        cyc();
        cyc();
        checks++;
        if ({stage, halted, instr_count} !== {2'b10, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL step_park got stage=%0d halted=%0b cnt=%0d exp 2 1 1", stage, halted, instr_count);
        end
        for (int n = 2; n < 4; n++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            cyc();
            cyc();
            cyc();
            checks++;
            if ({stage, halted, instr_count} !== {2'b10, 1'b1, 16'(n)}) begin
                failures++;
                $display("FAIL step%0d got stage=%0d halted=%0b cnt=%0d exp 2 1 %0d",
                         n, stage, halted, instr_count, n);
            end
        end
        halt_req = 1'b1;
        step     = 1'b1;
        cyc();
        checks++;
        if ({stage, halted} !== {2'b10, 1'b1}) begin
            failures++;
            $display("FAIL step_halt_wins got stage=%0d halted=%0b exp 2 1", stage, halted);
        end
        step      = 1'b0;
        halt_req  = 1'b0;
        step_mode = 1'b0;
        cyc();
        checks++;
        if (stage !== 2'b01) begin
            failures++;
            $display("FAIL step_mode_off got stage=%0d exp=1", stage);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
`ifdef SINGLE_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif
        test_reset();
        test_basic_load();
        test_valid_toggle();
        test_last_slot();
        test_halt();
        test_reset_mid();
        test_saturate();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
